// File: rtl/wb_csr_master_if.sv
// Command/response stream plus Wishbone classic bus of the CSR master.
// The master modport is the DUT side; slave is the driver/responder side.
interface wb_csr_master_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [ADDR_WIDTH-1:0] wb_adr_o;
    logic [DATA_WIDTH-1:0] wb_dat_o;
    logic [3:0]            wb_sel_o;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic                  wb_ack_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, wb_dat_i, wb_ack_i,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, wb_dat_i, wb_ack_i,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );
endinterface

// File: rtl/wb_csr_master.sv
// Single-outstanding Wishbone classic master for the UART CSR bus, with an
// ack timeout and a held response until the consumer takes it.
//
// state  | meaning
// S_IDLE | cmd_ready high, waiting for a command handshake
// S_BUS  | cyc/stb asserted, waiting for ack or timeout
// S_RESP | rsp_valid high, waiting for rsp_ready
module wb_csr_master #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                 clk,
    input  logic                 rstN,
    wb_csr_master_if.master      bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t                r_state, w_state;
    logic                  r_live;
    logic                  r_cyc, w_cyc;
    logic                  r_we, w_we;
    logic [ADDR_WIDTH-1:0] r_adr, w_adr;
    logic [DATA_WIDTH-1:0] r_dat, w_dat;
    logic [3:0]            r_sel, w_sel;
    logic [CW-1:0]         r_cnt, w_cnt;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata;
    logic                  r_err, w_err;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_live  <= 1'b1;
            r_cyc   <= w_cyc;
            r_we    <= w_we;
            r_adr   <= w_adr;
            r_dat   <= w_dat;
            r_sel   <= w_sel;
            r_cnt   <= w_cnt;
            r_rdata <= w_rdata;
            r_err   <= w_err;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cyc   = r_cyc;
        w_we    = r_we;
        w_adr   = r_adr;
        w_dat   = r_dat;
        w_sel   = r_sel;
        w_cnt   = r_cnt;
        w_rdata = r_rdata;
        w_err   = r_err;
        case (r_state)
            S_IDLE: begin
                if (r_live && bus.cmd_valid) begin
                    w_cyc   = 1'b1;
                    w_we    = bus.cmd_we;
                    w_adr   = bus.cmd_addr;
                    w_dat   = bus.cmd_wdata;
                    w_sel   = 4'b0001 << bus.cmd_addr[1:0];
                    w_cnt   = '0;
                    w_state = S_BUS;
                end
            end
            S_BUS: begin
                // ack is checked first so it wins over a same-cycle timeout
                if (bus.wb_ack_i || (r_cnt == CNT_LAST)) begin
                    w_cyc   = 1'b0;
                    w_we    = 1'b0;
                    w_adr   = '0;
                    w_dat   = '0;
                    w_sel   = '0;
                    w_err   = !bus.wb_ack_i;
                    w_rdata = (bus.wb_ack_i && !r_we) ? bus.wb_dat_i : '0;
                    w_state = S_RESP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_rdata = '0;
                    w_err   = 1'b0;
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.cmd_ready = r_live && (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign bus.wb_cyc_o  = r_cyc;
    assign bus.wb_stb_o  = r_cyc;
    assign bus.wb_we_o   = r_we;
    assign bus.wb_adr_o  = r_adr;
    assign bus.wb_dat_o  = r_dat;
    assign bus.wb_sel_o  = r_sel;
endmodule

// File: tb/tb_wb_csr_master.sv
// Directed bench for wb_csr_master: a table of single transactions with a
// scripted slave, plus reset, backpressure, stray-ack and mid-cycle reset cases.
module tb_wb_csr_master;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    int n_tests = 0;
    int n_fail  = 0;

    wb_csr_master_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus ();

    wb_csr_master #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .TIMEOUT(16)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] sdat;
        int         wait_cyc;
        logic [3:0] exp_sel;
        int         exp_stb;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_cmd_ready"}, bus.cmd_ready, 0);
        check({nm, "_rsp_valid"}, bus.rsp_valid, 0);
        check({nm, "_rsp_rdata"}, bus.rsp_rdata, 0);
        check({nm, "_rsp_err"},   bus.rsp_err,   0);
        check({nm, "_cyc"},       bus.wb_cyc_o,  0);
        check({nm, "_stb"},       bus.wb_stb_o,  0);
        check({nm, "_we"},        bus.wb_we_o,   0);
        check({nm, "_adr"},       bus.wb_adr_o,  0);
        check({nm, "_dat"},       bus.wb_dat_o,  0);
        check({nm, "_sel"},       bus.wb_sel_o,  0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        int stb_cycles;
        p = $sformatf("v%0d", idx);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = v.we;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        check({p, "_cmd_ready"}, bus.cmd_ready, 1);
        step();
        // scramble the command inputs: the bus must hold the registered copy
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = ~v.we;
        bus.cmd_addr  = ~v.addr;
        bus.cmd_wdata = ~v.wdata;
        check({p, "_cyc"}, bus.wb_cyc_o, 1);
        check({p, "_we"},  bus.wb_we_o, v.we);
        check({p, "_adr"}, bus.wb_adr_o, v.addr);
        check({p, "_dat"}, bus.wb_dat_o, v.wdata);
        check({p, "_sel"}, bus.wb_sel_o, v.exp_sel);
        check({p, "_busy_ready"}, bus.cmd_ready, 0);
        stb_cycles = 0;
        while (bus.wb_stb_o === 1'b1 && stb_cycles < 40) begin
            if (stb_cycles == v.wait_cyc) begin
                bus.wb_ack_i = 1'b1;
                bus.wb_dat_i = v.sdat;
            end
            step();
            bus.wb_ack_i = 1'b0;
            bus.wb_dat_i = 8'h00;
            stb_cycles++;
        end
        check({p, "_stb_cycles"}, stb_cycles, v.exp_stb);
        check({p, "_idle_adr"},  bus.wb_adr_o, 0);
        check({p, "_idle_sel"},  bus.wb_sel_o, 0);
        check({p, "_rsp_valid"}, bus.rsp_valid, 1);
        check({p, "_rsp_rdata"}, bus.rsp_rdata, v.exp_rdata);
        check({p, "_rsp_err"},   bus.rsp_err, v.exp_err);
        check({p, "_resp_ready"}, bus.cmd_ready, 0);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check({p, "_rsp_done"}, bus.rsp_valid, 0);
        check({p, "_ready_again"}, bus.cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //         we    addr   wdata  sdat   wait sel      stb rdata  err
        vecs[0] = '{1'b1, 5'h03, 8'h83, 8'h5A, 1,   4'b1000, 2,  8'h00, 1'b0};
        vecs[1] = '{1'b0, 5'h03, 8'h00, 8'h83, 0,   4'b1000, 1,  8'h83, 1'b0};
        vecs[2] = '{1'b0, 5'h00, 8'h00, 8'hC4, 3,   4'b0001, 4,  8'hC4, 1'b0};
        vecs[3] = '{1'b1, 5'h1E, 8'hFF, 8'h77, 2,   4'b0100, 3,  8'h00, 1'b0};
        vecs[4] = '{1'b0, 5'h05, 8'h00, 8'h3C, 16,  4'b0010, 16, 8'h00, 1'b1};
        vecs[5] = '{1'b0, 5'h11, 8'h00, 8'hA7, 15,  4'b0010, 16, 8'hA7, 1'b0};
        vecs[6] = '{1'b1, 5'h07, 8'h12, 8'hEE, 200, 4'b1000, 16, 8'h00, 1'b1};
        vecs[7] = '{1'b0, 5'h1F, 8'h00, 8'h99, 0,   4'b1000, 1,  8'h99, 1'b0};

        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.wb_dat_i  = '0;
        bus.wb_ack_i  = 1'b0;

        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            bus.cmd_valid = 1'($urandom);
            bus.cmd_we    = 1'($urandom);
            bus.cmd_addr  = 5'($urandom);
            bus.cmd_wdata = 8'($urandom);
            bus.rsp_ready = 1'($urandom);
            bus.wb_dat_i  = 8'($urandom);
            bus.wb_ack_i  = 1'($urandom);
            step();
            check_all_zero($sformatf("rst%0d", i));
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.wb_ack_i  = 1'b0;
        bus.wb_dat_i  = '0;
        rstN = 1'b1;
        step();
        check("rel_cmd_ready", bus.cmd_ready, 1);
        check("rel_cyc", bus.wb_cyc_o, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // response backpressure: rsp held, new command ignored
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = 5'h02;
        bus.cmd_wdata = 8'h00;
        step();
        bus.cmd_valid = 1'b0;
        bus.wb_ack_i  = 1'b1;
        bus.wb_dat_i  = 8'h6E;
        step();
        bus.wb_ack_i  = 1'b0;
        bus.wb_dat_i  = 8'h00;
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b1;
        bus.cmd_addr  = 5'h04;
        bus.cmd_wdata = 8'h55;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_rsp_valid", i), bus.rsp_valid, 1);
            check($sformatf("bp%0d_rsp_rdata", i), bus.rsp_rdata, 8'h6E);
            check($sformatf("bp%0d_rsp_err", i),   bus.rsp_err, 0);
            check($sformatf("bp%0d_cmd_ready", i), bus.cmd_ready, 0);
            check($sformatf("bp%0d_cyc", i),       bus.wb_cyc_o, 0);
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        check("bp_rsp_done", bus.rsp_valid, 0);
        check("bp_no_cycle", bus.wb_cyc_o, 0);
        check("bp_cmd_ready", bus.cmd_ready, 1);

        // stray ack while idle
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 8'hAB;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stray%0d_rsp_valid", i), bus.rsp_valid, 0);
            check($sformatf("stray%0d_cyc", i), bus.wb_cyc_o, 0);
            check($sformatf("stray%0d_cmd_ready", i), bus.cmd_ready, 1);
        end
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = 8'h00;

        // reset during BUS, then a late ack
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = 5'h01;
        step();
        bus.cmd_valid = 1'b0;
        check("mbus_stb", bus.wb_stb_o, 1);
        step();
        #2;
        rstN = 1'b0;
        #1;
        check_all_zero("mbus_rst");
        step();
        rstN = 1'b1;
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 8'hFF;
        step();
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = 8'h00;
        check("mbus_late_rsp", bus.rsp_valid, 0);
        check("mbus_late_stb", bus.wb_stb_o, 0);
        check("mbus_ready", bus.cmd_ready, 1);
        step();
        check("mbus_late_rsp2", bus.rsp_valid, 0);

        // reset during RESP
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = 5'h08;
        step();
        bus.cmd_valid = 1'b0;
        bus.wb_ack_i  = 1'b1;
        bus.wb_dat_i  = 8'h42;
        step();
        bus.wb_ack_i  = 1'b0;
        bus.wb_dat_i  = 8'h00;
        check("mresp_valid", bus.rsp_valid, 1);
        check("mresp_rdata", bus.rsp_rdata, 8'h42);
        #2;
        rstN = 1'b0;
        #1;
        check_all_zero("mresp_rst");
        step();
        rstN = 1'b1;
        step();
        check("mresp_after_rsp", bus.rsp_valid, 0);
        check("mresp_after_ready", bus.cmd_ready, 1);

        run_vec(vecs[2], 90);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
